aes_ecb_req_scheduler: RTL and testbench

Shares one pipelined Encrypt_AES_ECB core between NUM_REQ block requesters. Arbitrates round-robin among requesters with valid/ready handshakes and drives the core's enable, start and 128-bit data inputs. Tags each issued block with its requester ID and returns the ciphertext with that ID through a buffered response port. Sits between the host-side block sources and the ECB encrypt core.

---
 rtl/aes_ecb_req_scheduler_if.sv | 25 ++
 rtl/aes_ecb_req_scheduler.sv | 123 ++++++++++++
 tb/tb_aes_ecb_req_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ecb_req_scheduler_if.sv
// Requester/response bus of the AES-ECB request scheduler.
// The slave modport is the scheduler's view; the master modport is the host's view.
interface aes_ecb_req_scheduler_if #(
   parameter int NUM_REQ     = 2,
   parameter int INOUT_WIDTH = 128,
   parameter int ID_W        = 2
);
   logic [NUM_REQ-1:0]             req_valid_i;
   logic [NUM_REQ*INOUT_WIDTH-1:0] req_bytes_i;
   logic [NUM_REQ-1:0]             req_ready_o;
   logic                           rsp_valid_o;
   logic [INOUT_WIDTH-1:0]         rsp_bytes_o;
   logic [ID_W-1:0]                rsp_id_o;
   logic                           rsp_ready_i;

   modport slave (
      input  req_valid_i, req_bytes_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_bytes_o, rsp_id_o
   );

   modport master (
      output req_valid_i, req_bytes_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_bytes_o, rsp_id_o
   );
endinterface

// File: rtl/aes_ecb_req_scheduler.sv
// Round-robin scheduler sharing one pipelined AES-ECB core among NUM_REQ requesters,
// with credit-based flow control so the result FIFO can never overflow.
module aes_ecb_req_scheduler #(
   parameter int NUM_REQ     = 2,
   parameter int DEPTH       = 16,
   parameter int INOUT_WIDTH = 128,
   parameter int ID_W        = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   aes_ecb_req_scheduler_if.slave   bus,
   output logic                     core_rst_n_o,
   output logic                     core_enable_o,
   output logic                     core_start_o,
   output logic [INOUT_WIDTH-1:0]   core_bytes_o,
   input  logic                     core_busy_i,
   input  logic [INOUT_WIDTH-1:0]   core_bytes_i,
   input  logic                     core_valid_i,
   output logic [$clog2(DEPTH):0]   inflight_o,
   output logic                     err_o
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int RES_W = ID_W + INOUT_WIDTH;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]             st_q;
   logic [PTR_W-1:0]       rr_ptr_q;
   logic [CNT_W-1:0]       inflight_q;
   logic                   can_issue;
   logic                   grant_vld;
   logic [PTR_W-1:0]       grant_idx;
   logic [PTR_W:0]         scan_idx;
   logic [INOUT_WIDTH-1:0] grant_bytes;

   logic [ID_W-1:0]        tag_mem [DEPTH];
   logic [AW-1:0]          tag_wr_q, tag_rd_q;
   logic [CNT_W-1:0]       tag_cnt_q;
   logic                   tag_empty, tag_push, tag_pop;

   logic [RES_W-1:0]       res_mem [DEPTH];
   logic [AW-1:0]          res_wr_q, res_rd_q;
   logic [CNT_W-1:0]       res_cnt_q;
   logic                   res_valid, res_pop;

   assign core_rst_n_o  = ~rst_i;
   assign core_enable_o = (st_q == ST_RUN);
   assign inflight_o    = inflight_q;
   assign can_issue     = core_enable_o & ~core_busy_i & (inflight_q < CNT_W'(DEPTH));

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan_idx >= (PTR_W+1)'(NUM_REQ)) scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
         if (!grant_vld && can_issue && bus.req_valid_i[scan_idx[PTR_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx[PTR_W-1:0];
         end
      end
   end

   assign bus.req_ready_o = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
   assign grant_bytes     = bus.req_bytes_i[int'(grant_idx)*INOUT_WIDTH +: INOUT_WIDTH];

   assign tag_empty = (tag_cnt_q == '0);
   assign tag_push  = grant_vld;
   assign tag_pop   = core_valid_i & ~tag_empty;

   // Results are shown first-word-fall-through; outputs read zero while nothing is buffered.
   assign res_valid       = (res_cnt_q != '0);
   assign res_pop         = res_valid & bus.rsp_ready_i;
   assign bus.rsp_valid_o = res_valid;
   assign {bus.rsp_id_o, bus.rsp_bytes_o} = res_valid ? res_mem[res_rd_q] : '0;

   // NOTE: FIFO storage is deliberately not reset; the pointers and counts define validity.
   always_ff @(posedge clk_i) begin
      if (tag_push) tag_mem[tag_wr_q] <= ID_W'(grant_idx);
      if (tag_pop)  res_mem[res_wr_q] <= {tag_mem[tag_rd_q], core_bytes_i};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q         <= ST_IDLE;
         rr_ptr_q     <= '0;
         inflight_q   <= '0;
         core_start_o <= 1'b0;
         core_bytes_o <= '0;
         err_o        <= 1'b0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         tag_cnt_q    <= '0;
         res_wr_q     <= '0;
         res_rd_q     <= '0;
         res_cnt_q    <= '0;
      end else begin
         st_q         <= ST_RUN;
         core_start_o <= grant_vld;
         if (grant_vld) begin
            core_bytes_o <= grant_bytes;
            rr_ptr_q     <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
         end
         inflight_q <= inflight_q + CNT_W'(grant_vld) - CNT_W'(res_pop);
         // A return with no outstanding tag cannot be attributed; drop it and flag it.
         if (core_valid_i && tag_empty) err_o <= 1'b1;

         if (tag_push) tag_wr_q <= tag_wr_q + AW'(1);
         if (tag_pop)  tag_rd_q <= tag_rd_q + AW'(1);
         tag_cnt_q <= tag_cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);

         if (tag_pop) res_wr_q <= res_wr_q + AW'(1);
         if (res_pop) res_rd_q <= res_rd_q + AW'(1);
         res_cnt_q <= res_cnt_q + CNT_W'(tag_pop) - CNT_W'(res_pop);
      end
   end
endmodule

// File: tb/tb_aes_ecb_req_scheduler.sv
// Randomized bench for aes_ecb_req_scheduler: a fixed-latency core stand-in plus a
// transaction-level reference model (issue/return/pop counts and an expected-response queue).
module tb_aes_ecb_req_scheduler;
   localparam int NUM_REQ = 2;
   localparam int DEPTH   = 16;
   localparam int W       = 128;
   localparam int ID_W    = 2;
   localparam int LAT     = 3;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   aes_ecb_req_scheduler_if #(.NUM_REQ(NUM_REQ), .INOUT_WIDTH(W), .ID_W(ID_W)) bus ();

   logic                   core_rst_n_o, core_enable_o, core_start_o, err_o;
   logic [W-1:0]           core_bytes_o;
   logic [W-1:0]           core_bytes_i = '0;
   logic                   core_busy_i  = 1'b0;
   logic                   core_valid_i = 1'b0;
   logic [$clog2(DEPTH):0] inflight_o;

   aes_ecb_req_scheduler #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .INOUT_WIDTH(W), .ID_W(ID_W)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .bus          (bus),
      .core_rst_n_o (core_rst_n_o),
      .core_enable_o(core_enable_o),
      .core_start_o (core_start_o),
      .core_bytes_o (core_bytes_o),
      .core_busy_i  (core_busy_i),
      .core_bytes_i (core_bytes_i),
      .core_valid_i (core_valid_i),
      .inflight_o   (inflight_o),
      .err_o        (err_o)
   );

   typedef struct {
      logic [ID_W-1:0] id;
      logic [W-1:0]    ct;
   } rsp_t;

   rsp_t         exp_q[$];
   logic [W-1:0] pipe_q[$];
   int           due_q[$];
   int n_vec = 0, n_bad = 0, cyc = 0;

   int           m_ptr, m_issued, m_returned, m_popped;
   bit           m_en, m_err, m_start;
   logic [W-1:0] m_core_bytes;

   logic [NUM_REQ-1:0] v_mask;
   int           p_valid, p_busy, p_ready;
   bit           use_fixed, inject;
   logic [W-1:0] fixed_pt;

   // Stand-in for the encrypt core: any fixed bijection exposes routing/ordering errors.
   function automatic logic [W-1:0] cipher(input logic [W-1:0] pt);
      return {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_issued = 0; m_returned = 0; m_popped = 0;
      m_en = 0; m_err = 0; m_start = 0; m_core_bytes = '0;
      exp_q.delete(); pipe_q.delete(); due_q.delete();
   endtask

   // One clock cycle: drive at negedge, check 1 ns later, then advance the model past the next posedge.
   task automatic step(input bit do_rst);
      int g;
      logic [NUM_REQ-1:0] exp_rdy;
      bit rsp_vld;
      rsp_t e;
      @(negedge clk_i);
      rst_i = do_rst;
      for (int r = 0; r < NUM_REQ; r++) begin
         bus.req_valid_i[r] = v_mask[r] && (int'($urandom_range(99)) < p_valid);
         bus.req_bytes_i[r*W +: W] = (use_fixed && r == 0) ? fixed_pt
                                     : {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      core_busy_i     = (int'($urandom_range(99)) < p_busy);
      bus.rsp_ready_i = (int'($urandom_range(99)) < p_ready);
      core_valid_i    = 1'b0;
      core_bytes_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         core_valid_i = 1'b1;
         core_bytes_i = pipe_q.pop_front();
         void'(due_q.pop_front());
      end else if (inject && pipe_q.size() == 0) begin
         core_valid_i = 1'b1;
      end
      #1;
      check("core_rst_n", core_rst_n_o, !do_rst);
      check("core_enable", core_enable_o, m_en);
      check("core_start", core_start_o, m_start);
      check("core_bytes", core_bytes_o, m_core_bytes);
      check("inflight", inflight_o, m_issued - m_popped);
      check("err", err_o, m_err);

      g = -1;
      if (m_en && !core_busy_i && (m_issued - m_popped) < DEPTH)
         for (int k = 0; k < NUM_REQ; k++) begin
            int r;
            r = (m_ptr + k) % NUM_REQ;
            if (g < 0 && bus.req_valid_i[r]) g = r;
         end
      exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      check("req_ready", bus.req_ready_o, exp_rdy);

      rsp_vld = (m_returned - m_popped) > 0;
      check("rsp_valid", bus.rsp_valid_o, rsp_vld);
      if (rsp_vld) begin
         check("rsp_id", bus.rsp_id_o, exp_q[0].id);
         check("rsp_bytes", bus.rsp_bytes_o, exp_q[0].ct);
      end else if (m_returned == 0) begin
         check("rsp_id_idle", bus.rsp_id_o, 0);
         check("rsp_bytes_idle", bus.rsp_bytes_o, 0);
      end

      if (do_rst) begin
         model_reset();
      end else begin
         if (core_valid_i) begin
            if (m_returned < m_issued) m_returned++;
            else m_err = 1;
         end
         if (rsp_vld && bus.rsp_ready_i) begin
            m_popped++;
            void'(exp_q.pop_front());
         end
         if (g >= 0) begin
            e.id = ID_W'(g);
            e.ct = cipher(bus.req_bytes_i[g*W +: W]);
            exp_q.push_back(e);
            m_issued++;
            m_ptr = (g + 1) % NUM_REQ;
            m_start = 1;
            m_core_bytes = bus.req_bytes_i[g*W +: W];
         end else begin
            m_start = 0;
         end
         if (core_start_o) begin
            pipe_q.push_back(cipher(core_bytes_o));
            due_q.push_back(cyc + LAT);
         end
         m_en = 1;
      end
      cyc++;
   endtask

   initial begin
      v_mask = '0; p_valid = 0; p_busy = 0; p_ready = 100;
      use_fixed = 0; inject = 0;
      fixed_pt = 128'h00112233445566778899aabbccddeeff;
      bus.req_valid_i = '0; bus.req_bytes_i = '0; bus.rsp_ready_i = 1'b0;
      model_reset();

      step(1); step(1);
      repeat (3) step(0);

      // Single known block from requester 0.
      v_mask = 2'b01; p_valid = 100; use_fixed = 1;
      step(0);
      v_mask = '0; use_fixed = 0;
      repeat (10) step(0);

      // Both requesters saturating: grants must alternate.
      v_mask = 2'b11;
      repeat (8) step(0);
      v_mask = '0;
      repeat (12) step(0);

      // Credit stall, then a single pop releasing one credit.
      p_ready = 0; v_mask = 2'b11;
      repeat (24) step(0);
      check("credit_cap", inflight_o, DEPTH);
      p_ready = 100; step(0);
      p_ready = 0; repeat (4) step(0);
      v_mask = '0; p_ready = 100;
      repeat (30) step(0);

      // Core busy blocks issue.
      v_mask = 2'b10; p_busy = 100;
      repeat (5) step(0);
      p_busy = 0;
      repeat (2) step(0);
      v_mask = '0;
      repeat (10) step(0);

      // Orphan core return.
      inject = 1; step(0); inject = 0;
      repeat (3) step(0);
      check("err_sticky", err_o, 1);

      for (int blk = 0; blk < 30; blk++) begin
         v_mask = NUM_REQ'($urandom()); p_valid = $urandom_range(100);
         p_busy = $urandom_range(40);   p_ready = $urandom_range(100);
         repeat (50) step(0);
      end

      // Reset in the middle of traffic.
      v_mask = 2'b11; p_valid = 100; p_busy = 0; p_ready = 0;
      repeat (4) step(0);
      step(1);
      repeat (3) step(0);

      for (int blk = 0; blk < 10; blk++) begin
         v_mask = NUM_REQ'($urandom()); p_valid = $urandom_range(100);
         p_busy = $urandom_range(40);   p_ready = $urandom_range(100);
         repeat (50) step(0);
      end
      v_mask = '0; p_ready = 100;
      repeat (30) step(0);
      check("drained", inflight_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
